// File: rtl/s386_seq_pkg.sv
// Shared types and constants for the s386 vector sequencer and its compare stage.
// Entry layout is {expected, stim}, matching the host write-port format.
package s386_seq_pkg;
    localparam int S386_IW = 7;
    localparam int S386_OW = 7;

    // x^16 + x^12 + x^3 + x + 1, x^16 term implicit
    localparam logic [15:0] MISR_POLY = 16'h100B;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [S386_OW-1:0] expected;
        logic [S386_IW-1:0] stim;
    } pat_t;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
    endfunction
endpackage

// File: rtl/s386_seq_cmp.sv
// Compare pipeline: one capture register, then mismatch count / first-error / optional MISR (S386_SEQ_MISR_EN).
// Latency: result for a captured vector lands one edge after capture; no backpressure, accepts one vector per cycle.
module s386_seq_cmp
    import s386_seq_pkg::*;
#(
    parameter int AW     = 4,
    parameter int OW     = S386_OW,
    parameter int WARMUP = 2,
    parameter int CW     = 8
) (
    input  logic          CK,
    input  logic          RN,
    input  logic          clr,
    input  logic          cap_en,
    input  logic [OW-1:0] cap_out,
    input  logic [OW-1:0] cap_exp,
    input  logic [AW:0]   cap_idx,
    output logic [CW-1:0] err_cnt,
    output logic [AW-1:0] first_err,
`ifdef S386_SEQ_MISR_EN
    output logic [15:0]   signature,
`endif
    output logic          err_valid
);
    logic          vld_q, vld_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] exp_q, exp_d;
    logic [AW:0]   idx_q, idx_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0] first_err_q, first_err_d;
    logic          err_valid_q, err_valid_d;
    logic          cmp_en, mis;
`ifdef S386_SEQ_MISR_EN
    logic [15:0]   sig_q, sig_d;
`endif

    always_comb begin
        vld_d       = cap_en;
        out_d       = cap_en ? cap_out : out_q;
        exp_d       = cap_en ? cap_exp : exp_q;
        idx_d       = cap_en ? cap_idx : idx_q;
        cmp_en      = vld_q && (32'(idx_q) >= 32'(WARMUP));
        mis         = cmp_en && (out_q != exp_q);
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_valid_d = err_valid_q;
        if (clr) begin
            err_cnt_d   = '0;
            first_err_d = '0;
            err_valid_d = 1'b0;
        end else if (mis) begin
            if (err_cnt_q != '1)
                err_cnt_d = err_cnt_q + 1'b1;
            if (!err_valid_q) begin
                first_err_d = idx_q[AW-1:0];
                err_valid_d = 1'b1;
            end
        end
`ifdef S386_SEQ_MISR_EN
        sig_d = sig_q;
        if (clr)
            sig_d = MISR_SEED;
        else if (cmp_en)
            sig_d = misr_step(sig_q, 16'(out_q));
`endif
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            vld_q       <= 1'b0;
            out_q       <= '0;
            exp_q       <= '0;
            idx_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_valid_q <= 1'b0;
`ifdef S386_SEQ_MISR_EN
            sig_q       <= MISR_SEED;
`endif
        end else begin
            vld_q       <= vld_d;
            out_q       <= out_d;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_valid_q <= err_valid_d;
`ifdef S386_SEQ_MISR_EN
            sig_q       <= sig_d;
`endif
        end
    end

    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
    assign err_valid = err_valid_q;
`ifdef S386_SEQ_MISR_EN
    assign signature = sig_q;
`endif
endmodule

// File: rtl/s386_vec_sequencer.sv
// Sequences stored vectors into an s386 core and checks its outputs; S386_SEQ_MISR_EN adds a signature port.
// Latency: start at edge E -> done high the cycle after E+num_vec+1; no backpressure, start/wr_en ignored while busy.
module s386_vec_sequencer
    import s386_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int IW     = S386_IW,
    parameter int OW     = S386_OW,
    parameter int WARMUP = 2,
    parameter int CW     = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [IW+OW-1:0] wr_data,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    dut_in,
    input  logic [OW-1:0]    dut_out,
    output logic [CW-1:0]    err_cnt,
    output logic [AW-1:0]    first_err,
`ifdef S386_SEQ_MISR_EN
    output logic [15:0]      signature,
`endif
    output logic             err_valid
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    pat_t          mem_q [DEPTH];
    state_e        state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   last_q, last_d;
    logic [IW-1:0] dut_in_q, dut_in_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW:0]   nv_eff;
    logic          seq_start, cap_en;

    // Pattern memory has no reset; host reloads it before each campaign.
    always_ff @(posedge CK) begin
        if (wr_en && state_q == ST_IDLE)
            mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        nv_eff    = (num_vec == '0 || num_vec > DEPTH_W) ? DEPTH_W : num_vec;
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        dut_in_d  = dut_in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        seq_start = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    seq_start = 1'b1;
                    last_d    = nv_eff - 1'b1;
                    idx_d     = '0;
                    dut_in_d  = mem_q[0].stim;
                    busy_d    = 1'b1;
                end
            end
            ST_RUN: begin
                cap_en = 1'b1;
                if (idx_q == last_q) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    dut_in_d = mem_q[idx_d[AW-1:0]].stim;
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dut_in = dut_in_q;
    assign busy   = busy_q;
    assign done   = done_q;

    s386_seq_cmp #(
        .AW     (AW),
        .OW     (OW),
        .WARMUP (WARMUP),
        .CW     (CW)
    ) u_cmp (
        .CK        (CK),
        .RN        (RN),
        .clr       (seq_start),
        .cap_en    (cap_en),
        .cap_out   (dut_out),
        .cap_exp   (mem_q[idx_q[AW-1:0]].expected),
        .cap_idx   (idx_q),
        .err_cnt   (err_cnt),
        .first_err (first_err),
`ifdef S386_SEQ_MISR_EN
        .signature (signature),
`endif
        .err_valid (err_valid)
    );
endmodule

// File: tb/tb_s386_vec_sequencer.sv
// Randomized bench for s386_vec_sequencer with a behavioural core stand-in and a run-level reference model.
`timescale 1ns/1ps
module tb_s386_vec_sequencer;
    localparam int DEPTH = 16, AW = 4, IW = 7, OW = 7, WARMUP = 2, CW = 8;

    logic             CK = 1'b0, RN = 1'b0, wr_en = 1'b0, start = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [IW+OW-1:0] wr_data = '0;
    logic [AW:0]      num_vec = '0;
    logic             busy, done, err_valid;
    logic [IW-1:0]    dut_in;
    logic [OW-1:0]    dut_out;
    logic [CW-1:0]    err_cnt;
    logic [AW-1:0]    first_err;
`ifdef S386_SEQ_MISR_EN
    logic [15:0]      signature, sig_a;
`endif

    int n_cmp = 0, n_bad = 0;
    logic [IW-1:0] stim_m [DEPTH];
    logic [OW-1:0] exp_m  [DEPTH];
    logic [IW-1:0] core_prev = '0;
    logic [OW-1:0] stuck = '0;

    always #5 CK = ~CK;

    s386_vec_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW), .OW(OW), .WARMUP(WARMUP), .CW(CW)) dut (
        .CK(CK), .RN(RN), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .start(start), .busy(busy), .done(done),
        .dut_in(dut_in), .dut_out(dut_out), .err_cnt(err_cnt), .first_err(first_err),
`ifdef S386_SEQ_MISR_EN
        .signature(signature),
`endif
        .err_valid(err_valid)
    );

    // Stand-in core: one unreset state register holding the previous input.
    function automatic logic [OW-1:0] core_f(input logic [IW-1:0] cur, input logic [IW-1:0] prev);
        return cur ^ {prev[0], prev[IW-1:1]} ^ {OW{cur[0] & prev[3]}};
    endfunction

    always @(posedge CK) core_prev <= dut_in;
    assign dut_out = core_f(dut_in, core_prev) ^ stuck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_n(input int nv);
        return (nv == 0 || nv > DEPTH) ? DEPTH : nv;
    endfunction

    task automatic predict(input int n, output int cnt, output int first, output int valid,
                           output logic [15:0] sig);
        logic [OW-1:0] o;
        logic [16:0]   t;
        cnt = 0; first = 0; valid = 0; sig = 16'hFFFF;
        for (int k = WARMUP; k < n; k++) begin
            o = core_f(stim_m[k], stim_m[k-1]) ^ stuck;
            t = {sig, 1'b0};
            if (t[16]) t = t ^ 17'h1100B;
            sig = t[15:0] ^ {9'b0, o};
            if (o != exp_m[k]) begin
                if (cnt < (1 << CW) - 1) cnt++;
                if (valid == 0) begin first = k; valid = 1; end
            end
        end
    endtask

    task automatic golden();
        for (int k = 0; k < DEPTH; k++) stim_m[k] = IW'($urandom);
        exp_m[0] = OW'($urandom);
        for (int k = 1; k < DEPTH; k++) exp_m[k] = core_f(stim_m[k], stim_m[k-1]);
    endtask

    task automatic load();
        for (int k = 0; k < DEPTH; k++) begin
            @(posedge CK); #1;
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = {exp_m[k], stim_m[k]};
        end
        @(posedge CK); #1;
        wr_en = 1'b0;
    endtask

    task automatic run(input string tag, input int nv, input bit poke_start, input bit poke_wr);
        int n, cnt, first, valid, seen, extra;
        logic [15:0] sig;
        n = eff_n(nv);
        predict(n, cnt, first, valid, sig);
        @(posedge CK); #1;
        start = 1'b1; num_vec = (AW+1)'(nv);
        @(posedge CK); #1;
        start = 1'b0; num_vec = (AW+1)'($urandom_range(0, 31));
        seen = -1;
        for (int j = 0; j <= 60; j++) begin
            @(negedge CK);
            if (j == 0) check({tag, "_busy"}, busy, 1);
            if (done) begin seen = j; break; end
            @(posedge CK); #1;
            start = poke_start && (j == 3);
            wr_en = poke_wr && (j == 3);
            wr_addr = 4'd7;
            wr_data = {~exp_m[7], stim_m[7]};
        end
        start = 1'b0; wr_en = 1'b0;
        check({tag, "_lat"}, seen, n + 1);
        extra = 0;
        repeat (4) begin
            @(negedge CK);
            if (done) extra++;
        end
        check({tag, "_extra_done"}, extra, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_err_cnt"}, err_cnt, cnt);
        check({tag, "_first_err"}, first_err, first);
        check({tag, "_err_valid"}, err_valid, valid);
`ifdef S386_SEQ_MISR_EN
        check({tag, "_sig"}, signature, sig);
`else
        sig = '0;
`endif
    endtask

    initial begin
        int ne;
        RN = 1'b0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dut_in", dut_in, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err, 0);
        check("rst_err_valid", err_valid, 0);
`ifdef S386_SEQ_MISR_EN
        check("rst_sig", signature, 16'hFFFF);
`endif
        @(posedge CK); #1;
        RN = 1'b1;

        golden(); load();
        run("golden", 16, 0, 0);

        exp_m[5] = exp_m[5] ^ 7'h08;
        exp_m[9] = exp_m[9] ^ 7'($urandom_range(1, 127));
        load();
        run("fault", 16, 0, 0);

        golden();
        exp_m[1] = exp_m[1] ^ 7'h01;
        load();
        run("warmup", 16, 0, 0);
        run("one_vec", 1, 0, 0);

        golden(); load();
        run("start_in_run", 16, 1, 0);
        run("wr_in_run", 16, 0, 1);
        run("wr_readback", 16, 0, 0);
        run("nv_zero", 0, 0, 0);
        run("nv_over", 20, 0, 0);

        for (int it = 0; it < 8; it++) begin
            golden();
            for (int k = 0; k < DEPTH; k++)
                if ($urandom_range(0, 3) == 0) exp_m[k] = exp_m[k] ^ 7'($urandom_range(1, 127));
            load();
            run($sformatf("rand%0d", it), $urandom_range(0, 20), 0, 0);
        end

`ifdef S386_SEQ_MISR_EN
        golden(); load();
        run("misr_a", 16, 0, 0);
        sig_a = signature;
        run("misr_b", 16, 0, 0);
        check("misr_repeat", signature, sig_a);
        stuck = 7'h04;
        run("misr_stuck", 16, 0, 0);
        check("misr_differs", signature != sig_a, 1);
        stuck = '0;
`endif

        golden();
        exp_m[2] = exp_m[2] ^ 7'h01;
        load();
        @(posedge CK); #1;
        start = 1'b1; num_vec = 5'd16;
        @(posedge CK); #1;
        start = 1'b0;
        repeat (5) @(posedge CK);
        @(negedge CK);
        check("pre_rst_err_cnt", err_cnt, 1);
        check("pre_rst_busy", busy, 1);
        RN = 1'b0;
        @(posedge CK);
        @(negedge CK);
        check("midrst_busy", busy, 0);
        check("midrst_dut_in", dut_in, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_err_valid", err_valid, 0);
        RN = 1'b1;
        ne = 0;
        repeat (25) begin
            @(negedge CK);
            if (done) ne++;
        end
        check("midrst_no_done", ne, 0);
        check("midrst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
